// File: rtl/scs8hd_nor2b_pipe.sv
// ---------------------------------------------------------------------------
// scs8hd_nor2b_pipe
//
// Pipelined vector version of the nor2b cell. Each of WIDTH lanes computes
//   mode = 0 (nor2b): Y = ~A & BN
//   mode = 1 (nor2) : Y = ~(A | BN)
// The results and their popcount travel through a STAGES-deep,
// bubble-collapsing valid/ready pipeline. A saturating counter tracks the
// number of beats accepted at the output.
//
// Ports:
//   CLK        rising-edge clock
//   RESETB     asynchronous active-low reset
//   in_valid   input beat valid
//   in_ready   block can accept an input beat (combinational from out_ready)
//   A, BN      lane operands, WIDTH bits each
//   mode       0 = nor2b, 1 = nor2; sampled together with the beat
//   out_valid  output beat valid
//   out_ready  consumer accepts the output beat
//   Y          lane results from the last stage
//   y_ones     number of set bits in Y, carried with the beat
//   xfer_cnt   saturating count of accepted output beats
//   clr_cnt    synchronous clear of xfer_cnt (wins over an increment)
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module scs8hd_nor2b_pipe #(
    parameter  int WIDTH  = 8,
    parameter  int STAGES = 2,
    parameter  int CNT_W  = 16,
    localparam int POP_W  = $clog2(WIDTH + 1)
) (
    input  logic             CLK,
    input  logic             RESETB,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] BN,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic [POP_W-1:0] y_ones,
    output logic [CNT_W-1:0] xfer_cnt,
    input  logic             clr_cnt
);

    // Stage storage: index 0 is the first stage, STAGES-1 drives the outputs.
    logic [STAGES-1:0]             valid_q, valid_d;
    logic [STAGES-1:0][WIDTH-1:0]  y_q, y_d;
    logic [STAGES-1:0][POP_W-1:0]  ones_q, ones_d;
    logic [STAGES-1:0]             ready;
    logic [CNT_W-1:0]              xfer_cnt_q, xfer_cnt_d;

    logic [WIDTH-1:0] y_in;
    logic [POP_W-1:0] ones_in;

    // Lane logic and popcount, evaluated on the incoming operands.
    // NOTE: every variable written in an always_comb gets a default before any
    // conditional assignment, so no path leaves it unassigned (no latch).
    always_comb begin
        y_in    = mode ? ~(A | BN) : (~A & BN);
        ones_in = '0;
        for (int i = 0; i < WIDTH; i++) begin
            ones_in = ones_in + POP_W'(y_in[i]);
        end
    end

    // A stage can take a new beat if it, or any stage downstream of it,
    // holds a bubble, or if the consumer drains the last stage this cycle.
    // Written as an explicit OR over downstream valids so that no bit of
    // ready depends on another bit of the same vector.
    always_comb begin
        ready = '0;
        for (int i = 0; i < STAGES; i++) begin
            logic r;
            r = out_ready;
            for (int j = i; j < STAGES; j++) begin
                r = r | ~valid_q[j];
            end
            ready[i] = r;
        end
    end

    // Next state of the pipeline. Data registers only load when a valid beat
    // moves in, so a stage with valid low keeps its last contents.
    always_comb begin
        valid_d = valid_q;
        y_d     = y_q;
        ones_d  = ones_q;

        if (ready[0]) begin
            valid_d[0] = in_valid;
        end
        if (ready[0] && in_valid) begin
            y_d[0]    = y_in;
            ones_d[0] = ones_in;
        end

        for (int i = 1; i < STAGES; i++) begin
            if (ready[i]) begin
                valid_d[i] = valid_q[i-1];
            end
            if (ready[i] && valid_q[i-1]) begin
                y_d[i]    = y_q[i-1];
                ones_d[i] = ones_q[i-1];
            end
        end
    end

    // Saturating transfer counter; clear has priority over an increment.
    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (clr_cnt) begin
            xfer_cnt_d = '0;
        end else if (valid_q[STAGES-1] && out_ready && (xfer_cnt_q != '1)) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is written with non-blocking assignments only, so
    // every flop samples the pre-edge value of every other flop.
    // NOTE: the data registers are reset as well as the valids, because Y and
    // y_ones must read zero straight out of reset, not just out_valid.
    always_ff @(posedge CLK or negedge RESETB) begin
        if (!RESETB) begin
            valid_q    <= '0;
            y_q        <= '0;
            ones_q     <= '0;
            xfer_cnt_q <= '0;
        end else begin
            valid_q    <= valid_d;
            y_q        <= y_d;
            ones_q     <= ones_d;
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign in_ready  = ready[0];
    assign out_valid = valid_q[STAGES-1];
    assign Y         = y_q[STAGES-1];
    assign y_ones    = ones_q[STAGES-1];
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_scs8hd_nor2b_pipe.sv
// ---------------------------------------------------------------------------
// Testbench for scs8hd_nor2b_pipe.
//   dut_a: WIDTH=8, STAGES=2, CNT_W=4  -> directed latency, backpressure,
//          throughput, counter saturation/clear and mid-stream reset.
//   dut_b: WIDTH=1, STAGES=1           -> 10k random beats with random stalls.
// Expected beats come from a per-lane boolean reference and a FIFO scoreboard;
// occupancy of the scoreboard gives the expected in_ready.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_scs8hd_nor2b_pipe;

    localparam int NB = 10000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // dut_a signals
    logic       a_in_valid, a_in_ready, a_mode, a_out_valid, a_out_ready, a_clr;
    logic [7:0] a_a, a_bn, a_y;
    logic [3:0] a_ones;
    logic [3:0] a_cnt;

    // dut_b signals
    logic        b_in_valid, b_in_ready, b_mode, b_out_valid, b_out_ready, b_clr;
    logic [0:0]  b_a, b_bn, b_y;
    logic [0:0]  b_ones;
    logic [15:0] b_cnt;

    scs8hd_nor2b_pipe #(.WIDTH(8), .STAGES(2), .CNT_W(4)) dut_a (
        .CLK(clk), .RESETB(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready),
        .A(a_a), .BN(a_bn), .mode(a_mode),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .Y(a_y), .y_ones(a_ones), .xfer_cnt(a_cnt), .clr_cnt(a_clr)
    );

    scs8hd_nor2b_pipe #(.WIDTH(1), .STAGES(1), .CNT_W(16)) dut_b (
        .CLK(clk), .RESETB(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready),
        .A(b_a), .BN(b_bn), .mode(b_mode),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .Y(b_y), .y_ones(b_ones), .xfer_cnt(b_cnt), .clr_cnt(b_clr)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Lane-by-lane truth-table reference.
    function automatic logic [7:0] ref_y(input logic [7:0] a, input logic [7:0] bn, input logic m);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (m) r[i] = !(a[i] || bn[i]);
            else   r[i] = !a[i] && bn[i];
        end
        return r;
    endfunction

    // Scoreboard and counter model for dut_a.
    logic [7:0] qa[$];
    int a_popped = 0;
    int exp_a_cnt = 0;

    // Called at posedge+1 with inputs already set: samples the handshake just
    // before the next edge, updates the model, then advances one clock.
    task automatic a_edge();
        logic [7:0] e;
        #1;
        check("a_in_ready", a_in_ready, (qa.size() < 2) || a_out_ready);
        if (a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("a_spurious_beat", a_out_valid, 1'b0);
            end else begin
                e = qa.pop_front();
                check("a_y", a_y, e);
                check("a_ones", a_ones, $countones(e));
                a_popped++;
            end
        end
        if (a_clr) exp_a_cnt = 0;
        else if (a_out_valid && a_out_ready && exp_a_cnt < 15) exp_a_cnt++;
        if (a_in_valid && a_in_ready) qa.push_back(ref_y(a_a, a_bn, a_mode));
        @(posedge clk);
        #1;
        check("a_cnt", a_cnt, exp_a_cnt);
    endtask

    initial begin
        logic [0:0] qb[$];
        logic [7:0] tmp;
        logic [0:0] eb;
        int pc;
        int sent;
        int recv;
        logic acc_last;

        a_in_valid = 0; a_a = 0; a_bn = 0; a_mode = 0; a_out_ready = 1; a_clr = 0;
        b_in_valid = 0; b_a = 0; b_bn = 0; b_mode = 0; b_out_ready = 1; b_clr = 0;
        rst_n = 1;
        #1 rst_n = 0;
        #1;
        // Reset state, before any clock edge.
        check("rst_out_valid", a_out_valid, 0);
        check("rst_y", a_y, 0);
        check("rst_ones", a_ones, 0);
        check("rst_cnt", a_cnt, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_b_out_valid", b_out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;

        // Basic nor2b beat, accepted on the first edge after release.
        a_in_valid = 1; a_a = 8'h0F; a_bn = 8'hFF; a_mode = 0;
        a_edge();
        a_in_valid = 0;
        check("t1_not_yet_valid", a_out_valid, 0);
        a_edge();
        check("t1_out_valid", a_out_valid, 1);
        check("t1_y", a_y, 8'hF0);
        check("t1_ones", a_ones, 4);
        a_edge();
        check("t1_cnt", a_cnt, 1);
        check("t1_idle_valid", a_out_valid, 0);

        // nor2 beat.
        a_in_valid = 1; a_a = 8'h0F; a_bn = 8'h30; a_mode = 1;
        a_edge();
        a_in_valid = 0;
        a_edge();
        check("t2_y", a_y, 8'hC0);
        check("t2_ones", a_ones, 2);
        a_edge();

        // Back-to-back beats alternating mode: one output per cycle.
        pc = a_popped;
        for (int i = 0; i < 8; i++) begin
            a_in_valid = 1;
            a_a  = 8'($urandom);
            a_bn = 8'($urandom);
            a_mode = i[0];
            a_edge();
        end
        a_in_valid = 0;
        a_edge();
        a_edge();
        check("t2_throughput", a_popped - pc, 8);
        check("t2_drained", qa.size(), 0);

        // Backpressure: only two beats fit, order kept on release.
        a_out_ready = 0; a_in_valid = 1; a_bn = 8'hFF; a_mode = 0;
        a_a = 8'h01; a_edge();
        a_a = 8'h02; a_edge();
        a_a = 8'h03;
        #1 check("t3_full_in_ready", a_in_ready, 0);
        a_edge();
        check("t3_full_in_ready2", a_in_ready, 0);
        check("t3_head_valid", a_out_valid, 1);
        check("t3_head_y", a_y, 8'hFE);
        a_out_ready = 1;
        #1 check("t3_pass_through_ready", a_in_ready, 1);
        a_edge();
        a_in_valid = 0;
        repeat (3) a_edge();
        check("t3_drained", qa.size(), 0);

        // Counter: clear, saturate, then clear winning over a transfer.
        a_clr = 1; a_edge(); a_clr = 0;
        check("t4_cleared", a_cnt, 0);
        for (int i = 0; i < 20; i++) begin
            a_in_valid = 1; a_a = 8'($urandom); a_bn = 8'($urandom); a_mode = 1'($urandom_range(0, 1));
            a_edge();
        end
        a_in_valid = 0;
        repeat (3) a_edge();
        check("t4_saturated", a_cnt, 15);
        a_in_valid = 1; a_a = 8'h55; a_bn = 8'hAA; a_mode = 0;
        a_edge();
        a_in_valid = 0;
        a_edge();
        check("t4_beat_ready", a_out_valid, 1);
        a_clr = 1; a_edge(); a_clr = 0;
        check("t4_clr_wins", a_cnt, 0);
        check("t4_clr_beat_consumed", a_out_valid, 0);

        // Mid-stream asynchronous reset with a full pipeline.
        a_in_valid = 1; a_a = 8'h11; a_bn = 8'hFF; a_mode = 0;
        a_edge(); a_in_valid = 0; a_edge(); a_edge();
        a_out_ready = 0; a_in_valid = 1;
        a_a = 8'h21; a_edge();
        a_a = 8'h42; a_edge();
        a_in_valid = 0;
        check("t5_full", a_out_valid, 1);
        check("t5_cnt_before", a_cnt, 1);
        #2 rst_n = 0;
        #1;
        check("t5_out_valid", a_out_valid, 0);
        check("t5_y", a_y, 0);
        check("t5_ones", a_ones, 0);
        check("t5_cnt", a_cnt, 0);
        check("t5_in_ready", a_in_ready, 1);
        qa.delete();
        exp_a_cnt = 0;
        #1 rst_n = 1;
        @(posedge clk); #1;
        a_out_ready = 1;
        a_in_valid = 1; a_a = 8'h3C; a_bn = 8'hF0; a_mode = 0;
        a_edge();
        a_in_valid = 0;
        check("t5_post_lat0", a_out_valid, 0);
        a_edge();
        check("t5_post_valid", a_out_valid, 1);
        check("t5_post_y", a_y, 8'hC0);
        a_edge();

        // Random WIDTH=1, STAGES=1 run with stalls.
        sent = 0;
        recv = 0;
        acc_last = 1;
        for (int cyc = 0; cyc < 40000 && recv < NB; cyc++) begin
            if (!b_in_valid || acc_last) begin
                if (sent < NB && $urandom_range(0, 3) != 0) begin
                    b_in_valid = 1;
                    b_a    = 1'($urandom_range(0, 1));
                    b_bn   = 1'($urandom_range(0, 1));
                    b_mode = 1'($urandom_range(0, 1));
                end else begin
                    b_in_valid = 0;
                end
            end
            b_out_ready = ($urandom_range(0, 3) != 0);
            #1;
            check("b_in_ready", b_in_ready, (qb.size() < 1) || b_out_ready);
            check("b_out_valid", b_out_valid, qb.size() != 0);
            if (b_out_valid && b_out_ready && qb.size() != 0) begin
                eb = qb.pop_front();
                check("b_y", b_y, eb);
                check("b_ones", b_ones, eb);
                recv++;
            end
            acc_last = b_in_valid && b_in_ready;
            if (acc_last) begin
                tmp = ref_y(8'(b_a), 8'(b_bn), b_mode);
                qb.push_back(tmp[0]);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        b_in_valid = 0;
        check("b_all_received", recv, NB);
        check("b_cnt", b_cnt, NB);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scs8hd_nor2b_pipe.md
# scs8hd_nor2b_pipe

Parametrised, pipelined vector successor to the single-bit nor2b cell. Each of WIDTH lanes computes Y = ~A & BN (nor2b mode) or Y = ~(A | BN) (nor2 mode). Results travel through a STAGES-deep valid/ready pipeline that supports backpressure. The block also reports a per-beat popcount and a saturating transfer counter. It sits between a datapath producer and consumer wherever the team needs registered nor2b/nor2 masking of a bus.

## Interface
- WIDTH, 8, lane count (1..64)
- STAGES, 2, pipeline register stages (1..4); latency in cycles
- CNT_W, 16, width of transfer counter (2..32)
- POP_W, $clog2(WIDTH+1), popcount width (derived, not overridable)

Ports:
- CLK  in  1  rising-edge clock
- RESETB  in  1  asynchronous, active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept input beat
- A  in  WIDTH  true-polarity operand
- BN  in  WIDTH  operand (inverted-sense input in nor2b mode)
- mode  in  1  0 = nor2b (Y=~A&BN), 1 = nor2 (Y=~(A|BN)); sampled with beat
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output beat
- Y  out  WIDTH  lane results of last stage
- y_ones  out  POP_W  number of 1 bits in Y, travels with beat
- xfer_cnt  out  CNT_W  saturating count of accepted output beats
- clr_cnt  in  1  synchronous clear of xfer_cnt

## Operation
- Per-lane logic is evaluated combinationally at the input. Stage 1 captures Y and y_ones. Later stages carry them unchanged.
- Stage i holds {valid_i, Y_i, ones_i}. Stage i advances when ready_i is high, where ready_i = ~valid_i | ready_(i+1) and ready_(STAGES+1) = out_ready.
- in_ready = ready_1. An input beat is accepted on in_valid & in_ready.
- The pipeline is bubble-collapsing: a stage whose valid is low accepts upstream data even while downstream stalls.
- A stage whose valid is low does not update its data registers, so Y holds its last value while out_valid is low.
- out_valid = valid_STAGES; Y and y_ones are driven from the last stage.
- Order is preserved. No beat is ever dropped or duplicated. Capacity is STAGES beats.
- A beat presented with in_ready low must be held by the producer. The block does not capture it.
- xfer_cnt increments on out_valid & out_ready, saturates at 2^CNT_W-1, and never wraps.
- When clr_cnt and a transfer occur in the same cycle, clr_cnt wins and xfer_cnt = 0.

## Timing
- Reset (RESETB low) is asynchronous. All valid_i = 0, all Y_i = 0, all ones_i = 0, xfer_cnt = 0, taking effect immediately without a clock edge.
- Reset values of outputs: out_valid = 0, Y = 0, y_ones = 0, xfer_cnt = 0. in_ready = 1, combinational from the empty pipeline.
- Deassertion of reset is used synchronously. The first beat can be accepted on the first rising edge with RESETB high.
- Latency: a beat accepted at edge n appears with out_valid high after edge n+STAGES-1, when the pipeline is empty and out_ready is high. For STAGES=1, the result is visible right after the accepting edge.
- Throughput is one beat per cycle while out_ready stays high.
- With out_ready held low, exactly STAGES beats are accepted before in_ready drops to 0.
- Full pipeline with simultaneous out_ready and in_valid: the output beat is consumed and the input beat is accepted in the same cycle, so in_ready stays high.
- in_ready depends combinationally on out_ready; this is the only combinational input-to-output path besides the reset clear.
- Reset asserted mid-stream discards all in-flight beats. out_valid falls in the same cycle, asynchronously.

## Test plan
- WIDTH=8, STAGES=2, mode=0, A=0x0F, BN=0xFF, out_ready=1 -> Y=0xF0, y_ones=4, out_valid one cycle after the accept edge, xfer_cnt=1.
- mode=1, A=0x0F, BN=0x30 -> Y=0xC0, y_ones=2. Back-to-back beats alternating mode 0/1 on every cycle -> one output beat per cycle, each with correct per-beat mode.
- out_ready=0, push beats 0x01,0x02,0x03 (A=beat, BN=0xFF, mode 0) -> in_ready low after 2 accepts. Raise out_ready -> Y sequence 0xFE,0xFD,0xFC in order, no loss.
- CNT_W=4, 20 consecutive transfers -> xfer_cnt saturates at 15. clr_cnt pulsed together with a transfer -> xfer_cnt=0.
- Pipeline full, RESETB pulsed low between clock edges -> out_valid=0, Y=0, y_ones=0 immediately. After release, the next beat has normal latency.
- WIDTH=1, STAGES=1, random A/BN/mode with random out_ready stalls -> scoreboard matches ~A&BN or ~(A|BN) bit-exactly over 10k beats.
